// File: rtl/stream_mux_rr.sv
// N:1 streaming multiplexer with a registered output stage and a channel tag.
// Grants either round-robin across requesting channels or a fixed channel from sel.
module stream_mux_rr #(
  parameter int WIDTH = 3,
  parameter int NCH   = 8,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] grant;
  logic            grant_vld;
  logic            load_en;
  logic            xfer;

  // Output register is empty or drains this cycle, so it can take a new word.
  assign load_en = !out_valid || out_ready;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant_vld = 1'b0;
    grant     = '0;
    if (mode) begin
      // Indices >= NCH never match, so an out-of-range sel grants nothing.
      for (int i = 0; i < NCH; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant     = SELW'(i);
        end
      end
    end else begin
      // Scan from the farthest offset down so the nearest requester after rr_ptr wins;
      // offset NCH lands on rr_ptr itself, which keeps a lone requester from starving.
      for (int off = NCH; off >= 1; off--) begin
        if (in_valid[(int'(rr_ptr) + off) % NCH]) begin
          grant_vld = 1'b1;
          grant     = SELW'((int'(rr_ptr) + off) % NCH);
        end
      end
    end
  end

  assign xfer     = rst_n && load_en && grant_vld;
  assign in_ready = xfer ? (NCH'(1) << grant) : '0;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= SELW'(NCH - 1);
    end else if (xfer) begin
      out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
      out_chan  <= grant;
      out_valid <= 1'b1;
      if (!mode) rr_ptr <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: a reference model pushes expected words
// into a scoreboard when a transfer is predicted and pops them as the DUT delivers.
module tb_stream_mux_rr;

  localparam int WIDTH = 3;
  localparam int NCH   = 8;
  localparam int SELW  = $clog2(NCH);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_chan;
  logic                 out_valid;
  logic                 out_ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [SELW+WIDTH-1:0] sb_q[$];
  int   m_ptr    = NCH - 1;
  logic m_ovalid = 1'b0;

  stream_mux_rr #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [NCH-1:0] v, input logic m,
                                     input logic [SELW-1:0] s, input int ptr);
    if (m) return (int'(s) < NCH && v[s]) ? int'(s) : -1;
    for (int i = 1; i <= NCH; i++) begin
      int c;
      c = (ptr + i) % NCH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  always @(negedge rst_n) begin
    m_ovalid = 1'b0;
    m_ptr    = NCH - 1;
    sb_q.delete();
  end

  // Monitor at the falling edge: inputs are stable and reflect the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      int g;
      logic load;
      logic [NCH-1:0] exp_rdy;
      logic [SELW+WIDTH-1:0] exp_w;
      g    = model_grant(in_valid, mode, sel, m_ptr);
      load = !m_ovalid || out_ready;
      check("out_valid", out_valid, m_ovalid);
      if (m_ovalid) begin
        if (sb_q.size() == 0) begin
          check("sb_empty", 1, 0);
        end else begin
          exp_w = sb_q[0];
          check("out_chan", out_chan, exp_w[SELW+WIDTH-1:WIDTH]);
          check("out_data", out_data, exp_w[WIDTH-1:0]);
          if (out_ready) void'(sb_q.pop_front());
        end
      end
      exp_rdy = (load && g >= 0) ? (NCH'(1) << g) : '0;
      check("in_ready", in_ready, exp_rdy);
      if (load && g >= 0) begin
        sb_q.push_back({SELW'(g), in_data[g*WIDTH +: WIDTH]});
        m_ovalid = 1'b1;
        if (!mode) m_ptr = g;
      end else if (out_ready) begin
        m_ovalid = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b1;
    for (int i = 0; i < NCH; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(i);
    step(2);
    rst_n = 1'b1;

    // Idle after reset.
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_chan", out_chan, 0);
      check("rst_ready", in_ready, 0);
    end

    // Fairness with all channels valid.
    in_valid = 8'hFF;
    for (int k = 0; k < 16; k++) begin
      step(1);
      check("fair_chan", out_chan, k % NCH);
      check("fair_valid", out_valid, 1);
    end

    // Two requesters alternate, then a lone requester is re-granted.
    in_valid = 8'b1000_0100;
    for (int k = 0; k < 4; k++) begin
      step(1);
      check("alt_chan", out_chan, (k % 2 == 0) ? 2 : 7);
    end
    in_valid = 8'b1000_0000;
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("lone_chan", out_chan, 7);
    end

    // Fixed select.
    mode     = 1'b1;
    sel      = 3'd5;
    in_valid = 8'hFF;
    #1 check("fix_ready", in_ready, 8'h20);
    for (int k = 0; k < 4; k++) begin
      step(1);
      check("fix_chan", out_chan, 5);
      check("fix_data", out_data, 3'b101);
    end
    in_valid[5] = 1'b0;
    step(1);
    check("fix_drop", out_valid, 0);

    // Stall holding a word from channel 3, then drain and load channel 4 together.
    mode     = 1'b0;
    in_valid = 8'h08;
    step(1);
    check("stall_load", out_chan, 3);
    in_valid  = 8'hFF;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      check("stall_chan", out_chan, 3);
      check("stall_data", out_data, 3);
      check("stall_valid", out_valid, 1);
      check("stall_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1 check("resume_ready", in_ready, 8'h10);
    step(1);
    check("resume_chan", out_chan, 4);
    step(2);
    check("pre_rst_chan", out_chan, 6);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1 check("async_valid", out_valid, 0);
    check("async_ready", in_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1);
    check("post_rst_chan", out_chan, 0);

    // Drain the scoreboard.
    in_valid = '0;
    step(3);
    check("sb_left", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N:1 streaming data multiplexer, the successor to the team's fixed 8:1 combinational mux.
- Each channel has a valid/ready handshake. One registered output stage carries a channel tag.
- Two selection modes: round-robin arbitration across requesting channels, or a fixed select from a `sel` input.
- Sits between parallel producers and a single downstream consumer. Throughput is one word per cycle.

Parameters:
- WIDTH, 3, data bits per channel.
- NCH, 8, number of input channels (must be >= 2).
- SELW, $clog2(NCH), width of select and channel-tag fields.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready; a transfer on channel i occurs when in_valid[i] && in_ready[i].
- mode  input  1  0 = round-robin, 1 = fixed select.
- sel  input  SELW  channel index used when mode=1.
- out_data  output  WIDTH  registered selected word.
- out_chan  output  SELW  registered index of the channel that supplied out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_chan=0, rr_ptr=NCH-1. This makes channel 0 highest priority after reset. No in_ready asserted while rst_n is low.
- load_en = !out_valid || out_ready. It is combinational and means the output register is empty or draining this cycle.
- Grant in mode 0: the first i with in_valid[i]=1, searched circularly starting at (rr_ptr+1) mod NCH.
- Grant in mode 1: channel sel, only if in_valid[sel]=1. If sel >= NCH, nothing is granted.
- in_ready[i] = load_en && (grant valid) && (grant==i). At most one bit is set. in_ready may depend on in_valid; in_valid must never depend on in_ready.
- On a transfer at a clock edge:
  - out_data <= word of the granted channel; out_chan <= its index; out_valid <= 1.
  - In mode 0, rr_ptr <= the granted index.
  - In mode 1, rr_ptr is unchanged.
- Drain with no new grant: if out_valid && out_ready and no channel is granted, then out_valid <= 0. out_data and out_chan hold their last values.
- Stall: while out_valid && !out_ready, out_data, out_chan and out_valid hold stable and all in_ready are 0.
- Latency: 1 cycle from input transfer to out_valid. Back-to-back transfers every cycle are allowed when out_ready stays high.
- Simultaneous drain and load: the new word replaces the old one in the same edge, with no bubble.
- Mode or sel changes:
  - Sampled combinationally each cycle; they affect only the next grant.
  - A held output word is never altered.
  - rr_ptr keeps its value across a mode switch.
- Wrap-around: rr_ptr=NCH-1 searches from 0. Grant with rr_ptr=k and only channel k requesting selects k again (a lone requester is not starved).
- Fairness: with all NCH channels continuously valid and out_ready=1 in mode 0, grants cycle 0,1,...,NCH-1,0,... Each channel gets exactly one word per NCH cycles.
- Reset mid-operation: the held word is discarded immediately (out_valid=0), and rr_ptr returns to NCH-1.
- No combinational path from out_ready to out_data, out_chan or out_valid. The only such path is out_ready to in_ready.

Test Plan (WIDTH=3, NCH=8, in_data channel i = i unless stated):
- Reset release, all in_valid=0 -> out_valid=0, out_data=0, out_chan=0, in_ready=0 for 10 cycles.
- Mode 0, in_valid=8'hFF, out_ready=1 for 16 cycles -> out_chan sequence 0..7,0..7, out_data=out_chan each cycle, no bubbles.
- Mode 0, in_valid=8'b1000_0100, out_ready=1 -> out_chan alternates 2,7,2,7. Then drop in_valid[2] -> 7,7,7 (lone requester re-granted).
- Mode 1, sel=5, in_valid=8'hFF -> only in_ready[5] asserted, out_chan=5, out_data=3'b101 every cycle. Then in_valid[5]=0 -> out_valid falls after one cycle.
- Stall: word from channel 3 loaded, then out_ready=0 for 4 cycles with in_valid=8'hFF -> out_data=3, out_chan=3 stable, in_ready=0. Then out_ready=1 -> next grant is channel 4 on the same edge the old word drains.
- Mid-stream reset: out_valid=1, out_chan=6, assert rst_n=0 between edges -> out_valid=0 immediately. After release with in_valid=8'hFF -> first out_chan=0.
